// File: rtl/mipi_seq_pkg.sv
// Shared types and constants for the MIPI D-PHY lane sequencer.
package mipi_seq_pkg;

  localparam int CNT_W = 8;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam int DEF_T_LPX       = 2;
  localparam int DEF_T_HS_PREP   = 1;
  localparam int DEF_T_HS_ZERO   = 5;
  localparam int DEF_T_HS_TRAIL  = 3;
  localparam int DEF_T_HS_EXIT   = 4;
  localparam int DEF_T_CLK_ZERO  = 12;
  localparam int DEF_T_CLK_PRE   = 2;
  localparam int DEF_T_CLK_POST  = 4;
  localparam int DEF_T_CLK_TRAIL = 2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLK_LPX   = 4'd1,
    ST_CLK_PREP  = 4'd2,
    ST_CLK_ZERO  = 4'd3,
    ST_CLK_PRE   = 4'd4,
    ST_DAT_LPX   = 4'd5,
    ST_DAT_PREP  = 4'd6,
    ST_DAT_ZERO  = 4'd7,
    ST_SYNC      = 4'd8,
    ST_PAYLOAD   = 4'd9,
    ST_TRAIL     = 4'd10,
    ST_DAT_EXIT  = 4'd11,
    ST_CLK_POST  = 4'd12,
    ST_CLK_TRAIL = 4'd13,
    ST_CLK_EXIT  = 4'd14
  } state_t;

  // Line levels of both lanes for one state.
  typedef struct packed {
    logic clk_lp0;
    logic clk_lp1;
    logic tristate_clk;
    logic dat_lp0;
    logic dat_lp1;
    logic tristate_data;
  } lane_out_t;

  // LP levels and HS driver enables as a pure function of the state.
  // A lane whose HS driver is on holds its LP pair at 00.
  function automatic lane_out_t lane_out(input state_t s);
    lane_out_t o;
    o = '{clk_lp0: 1'b1, clk_lp1: 1'b1, tristate_clk: 1'b1,
          dat_lp0: 1'b1, dat_lp1: 1'b1, tristate_data: 1'b1};
    case (s)
      ST_CLK_LPX: o.clk_lp0 = 1'b0;
      ST_CLK_PREP: begin
        o.clk_lp0 = 1'b0;
        o.clk_lp1 = 1'b0;
      end
      ST_CLK_ZERO, ST_CLK_PRE, ST_DAT_EXIT, ST_CLK_POST, ST_CLK_TRAIL: begin
        o.clk_lp0      = 1'b0;
        o.clk_lp1      = 1'b0;
        o.tristate_clk = 1'b0;
      end
      ST_DAT_LPX: begin
        o.clk_lp0      = 1'b0;
        o.clk_lp1      = 1'b0;
        o.tristate_clk = 1'b0;
        o.dat_lp0      = 1'b0;
      end
      ST_DAT_PREP: begin
        o.clk_lp0      = 1'b0;
        o.clk_lp1      = 1'b0;
        o.tristate_clk = 1'b0;
        o.dat_lp0      = 1'b0;
        o.dat_lp1      = 1'b0;
      end
      ST_DAT_ZERO, ST_SYNC, ST_PAYLOAD, ST_TRAIL: begin
        o.clk_lp0       = 1'b0;
        o.clk_lp1       = 1'b0;
        o.tristate_clk  = 1'b0;
        o.dat_lp0       = 1'b0;
        o.dat_lp1       = 1'b0;
        o.tristate_data = 1'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

  // Trail bytes are the inverse of the final payload bit so the line toggles.
  function automatic logic [7:0] trail_byte(input logic [7:0] last_byte);
    return last_byte[7] ? 8'h00 : 8'hFF;
  endfunction

endpackage

// File: rtl/mipi_seq_timer.sv
// Loadable down-counter; done is high while the count is at or below one,
// so a value N loaded on state entry yields a state lasting N cycles.
module mipi_seq_timer
  import mipi_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Load on state entry, otherwise count down and saturate at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count <= CNT_W'(1));

endmodule

// File: rtl/mipi_lane_sequencer.sv
// Drives one clock lane and one data lane through the LP -> HS -> LP burst
// sequence. Every output is registered from the next state, so outputs
// change on the same edge that enters a state.
//
// Payload handshake: a byte transfers on a rising edge where s_valid_i and
// s_ready_o are both high. s_ready_o is registered, high in SYNC and PAYLOAD
// and low from the edge that accepts s_last_i. Valid low while ready is high
// in PAYLOAD is an underrun and ends the burst.
module mipi_lane_sequencer
  import mipi_seq_pkg::*;
#(
  parameter int unsigned T_LPX       = DEF_T_LPX,
  parameter int unsigned T_HS_PREP   = DEF_T_HS_PREP,
  parameter int unsigned T_HS_ZERO   = DEF_T_HS_ZERO,
  parameter int unsigned T_HS_TRAIL  = DEF_T_HS_TRAIL,
  parameter int unsigned T_HS_EXIT   = DEF_T_HS_EXIT,
  parameter int unsigned T_CLK_ZERO  = DEF_T_CLK_ZERO,
  parameter int unsigned T_CLK_PRE   = DEF_T_CLK_PRE,
  parameter int unsigned T_CLK_POST  = DEF_T_CLK_POST,
  parameter int unsigned T_CLK_TRAIL = DEF_T_CLK_TRAIL
) (
  input  logic       byte_clock_i,
  input  logic       reset_i,
  input  logic       tx_ready_i,
  input  logic       hs_request_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic       clk_lp0_o,
  output logic       clk_lp1_o,
  output logic       tristate_clk_o,
  output logic       dat_lp0_o,
  output logic       dat_lp1_o,
  output logic       tristate_data_o,
  output logic [7:0] hs_data_o,
  output logic       busy_o,
  output logic       underrun_o
);

  state_t           state_q;
  state_t           state_d;
  logic             tmr_done;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             accept;
  logic             underrun_evt;
  logic             s_ready_d;
  logic [7:0]       hs_data_d;
  lane_out_t        lanes_d;

  mipi_seq_timer u_timer (
    .clk        (byte_clock_i),
    .reset      (reset_i),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  // Next-state logic; hs_request_i and tx_ready_i only matter in IDLE.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    underrun_evt = 1'b0;
    case (state_q)
      ST_IDLE:      if (hs_request_i && tx_ready_i) state_d = ST_CLK_LPX;
      ST_CLK_LPX:   if (tmr_done) state_d = ST_CLK_PREP;
      ST_CLK_PREP:  if (tmr_done) state_d = ST_CLK_ZERO;
      ST_CLK_ZERO:  if (tmr_done) state_d = ST_CLK_PRE;
      ST_CLK_PRE:   if (tmr_done) state_d = ST_DAT_LPX;
      ST_DAT_LPX:   if (tmr_done) state_d = ST_DAT_PREP;
      ST_DAT_PREP:  if (tmr_done) state_d = ST_DAT_ZERO;
      // HS-zero stretches until the source has a byte ready.
      ST_DAT_ZERO:  if (tmr_done && s_valid_i) state_d = ST_SYNC;
      ST_SYNC, ST_PAYLOAD: begin
        if (!s_ready_o) begin
          // Final byte has had its one cycle on the wire.
          state_d = ST_TRAIL;
        end else if (s_valid_i) begin
          accept  = 1'b1;
          state_d = ST_PAYLOAD;
        end else begin
          underrun_evt = 1'b1;
          state_d      = ST_TRAIL;
        end
      end
      ST_TRAIL:     if (tmr_done) state_d = ST_DAT_EXIT;
      ST_DAT_EXIT:  if (tmr_done) state_d = ST_CLK_POST;
      ST_CLK_POST:  if (tmr_done) state_d = ST_CLK_TRAIL;
      ST_CLK_TRAIL: if (tmr_done) state_d = ST_CLK_EXIT;
      ST_CLK_EXIT:  if (tmr_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Duration of the state being entered; loaded only on a state change.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_CLK_LPX, ST_DAT_LPX:   tmr_value = CNT_W'(T_LPX);
      ST_CLK_PREP, ST_DAT_PREP: tmr_value = CNT_W'(T_HS_PREP);
      ST_CLK_ZERO:              tmr_value = CNT_W'(T_CLK_ZERO);
      ST_CLK_PRE:               tmr_value = CNT_W'(T_CLK_PRE);
      ST_DAT_ZERO:              tmr_value = CNT_W'(T_HS_ZERO);
      ST_SYNC:                  tmr_value = CNT_W'(1);
      ST_TRAIL:                 tmr_value = CNT_W'(T_HS_TRAIL);
      ST_DAT_EXIT, ST_CLK_EXIT: tmr_value = CNT_W'(T_HS_EXIT);
      ST_CLK_POST:              tmr_value = CNT_W'(T_CLK_POST);
      ST_CLK_TRAIL:             tmr_value = CNT_W'(T_CLK_TRAIL);
      default:                  tmr_value = '0;
    endcase
  end

  // Next values of the registered data-path outputs.
  always_comb begin
    lanes_d   = lane_out(state_d);
    s_ready_d = (state_d == ST_SYNC) ||
                ((state_d == ST_PAYLOAD) && accept && !s_last_i);
    case (state_d)
      ST_SYNC:    hs_data_d = SYNC_BYTE;
      ST_PAYLOAD: hs_data_d = accept ? s_data_i : hs_data_o;
      // Trail pattern is fixed on entry from the byte last on the wire.
      ST_TRAIL:   hs_data_d = (state_q == ST_TRAIL) ? hs_data_o
                                                    : trail_byte(hs_data_o);
      default:    hs_data_d = 8'h00;
    endcase
  end

  // State and output registers; reset parks both lanes at LP-11.
  always_ff @(posedge byte_clock_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      clk_lp0_o       <= 1'b1;
      clk_lp1_o       <= 1'b1;
      tristate_clk_o  <= 1'b1;
      dat_lp0_o       <= 1'b1;
      dat_lp1_o       <= 1'b1;
      tristate_data_o <= 1'b1;
      hs_data_o       <= 8'h00;
      s_ready_o       <= 1'b0;
      busy_o          <= 1'b0;
      underrun_o      <= 1'b0;
    end else begin
      state_q         <= state_d;
      clk_lp0_o       <= lanes_d.clk_lp0;
      clk_lp1_o       <= lanes_d.clk_lp1;
      tristate_clk_o  <= lanes_d.tristate_clk;
      dat_lp0_o       <= lanes_d.dat_lp0;
      dat_lp1_o       <= lanes_d.dat_lp1;
      tristate_data_o <= lanes_d.tristate_data;
      hs_data_o       <= hs_data_d;
      s_ready_o       <= s_ready_d;
      busy_o          <= (state_d != ST_IDLE);
      if (underrun_evt) underrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mipi_lane_sequencer.sv
// Directed bench for mipi_lane_sequencer: per-scenario tables of output
// segments expanded into an expected queue and compared every cycle.
module tb_mipi_lane_sequencer;

  logic       byte_clock_i = 1'b0;
  logic       reset_i      = 1'b1;
  logic       tx_ready_i   = 1'b0;
  logic       hs_request_i = 1'b0;
  logic [7:0] s_data_i     = 8'h00;
  logic       s_valid_i    = 1'b0;
  logic       s_last_i     = 1'b0;
  logic       s_ready_o;
  logic       clk_lp0_o, clk_lp1_o, tristate_clk_o;
  logic       dat_lp0_o, dat_lp1_o, tristate_data_o;
  logic [7:0] hs_data_o;
  logic       busy_o, underrun_o;

  mipi_lane_sequencer dut (
    .byte_clock_i    (byte_clock_i),
    .reset_i         (reset_i),
    .tx_ready_i      (tx_ready_i),
    .hs_request_i    (hs_request_i),
    .s_data_i        (s_data_i),
    .s_valid_i       (s_valid_i),
    .s_last_i        (s_last_i),
    .s_ready_o       (s_ready_o),
    .clk_lp0_o       (clk_lp0_o),
    .clk_lp1_o       (clk_lp1_o),
    .tristate_clk_o  (tristate_clk_o),
    .dat_lp0_o       (dat_lp0_o),
    .dat_lp1_o       (dat_lp1_o),
    .tristate_data_o (tristate_data_o),
    .hs_data_o       (hs_data_o),
    .busy_o          (busy_o),
    .underrun_o      (underrun_o)
  );

  // ---------------- clock ----------------
  always #5 byte_clock_i = ~byte_clock_i;

  // Lane codes: {clk_lp0, clk_lp1, tristate_clk, dat_lp0, dat_lp1, tristate_data}
  localparam logic [5:0] L_IDLE  = 6'b11_1_11_1;
  localparam logic [5:0] L_CLPX  = 6'b01_1_11_1;
  localparam logic [5:0] L_CPREP = 6'b00_1_11_1;
  localparam logic [5:0] L_CHS   = 6'b00_0_11_1;
  localparam logic [5:0] L_DLPX  = 6'b00_0_01_1;
  localparam logic [5:0] L_DPREP = 6'b00_0_00_1;
  localparam logic [5:0] L_DHS   = 6'b00_0_00_0;

  typedef struct {
    string       name;
    int          n;
    logic [16:0] exp;
  } seg_t;

  seg_t        segs[$];
  logic [16:0] exp_q[$];
  string       name_q[$];

  int tests = 0;
  int fails = 0;

  // scenario stimulus controls (edge indices relative to scenario start)
  int         req_from, req_to, rdy_from, txd_from, txd_to, valid_from, drop_at;
  logic [7:0] src_q[$];
  int         src_idx;
  int         k;

  function automatic logic [16:0] vec(input logic [5:0] lanes, input logic [7:0] hs,
                                      input logic rdy, input logic busy, input logic urun);
    return {lanes, hs, rdy, busy, urun};
  endfunction

  function automatic logic [16:0] act_vec();
    return {clk_lp0_o, clk_lp1_o, tristate_clk_o, dat_lp0_o, dat_lp1_o,
            tristate_data_o, hs_data_o, s_ready_o, busy_o, underrun_o};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int idx, input logic [16:0] got,
                       input logic [16:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got lanes=%b hs=%h rdy/busy/urun=%b, expected lanes=%b hs=%h rdy/busy/urun=%b",
               name, idx, got[16:11], got[10:3], got[2:0], exp[16:11], exp[10:3], exp[2:0]);
    end
  endtask

  task automatic add_seg(input string name, input int n, input logic [5:0] lanes,
                         input logic [7:0] hs, input logic rdy, input logic busy,
                         input logic urun);
    seg_t s;
    s.name = name;
    s.n    = n;
    s.exp  = vec(lanes, hs, rdy, busy, urun);
    segs.push_back(s);
  endtask

  task automatic add_pre();
    add_seg("clk_lpx",  2,  L_CLPX,  8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("clk_prep", 1,  L_CPREP, 8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("clk_zero", 12, L_CHS,   8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("clk_pre",  2,  L_CHS,   8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("dat_lpx",  2,  L_DLPX,  8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("dat_prep", 1,  L_DPREP, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic add_post(input logic urun);
    add_seg("dat_exit",  4, L_CHS,  8'h00, 1'b0, 1'b1, urun);
    add_seg("clk_post",  4, L_CHS,  8'h00, 1'b0, 1'b1, urun);
    add_seg("clk_trail", 2, L_CHS,  8'h00, 1'b0, 1'b1, urun);
    add_seg("clk_exit",  4, L_IDLE, 8'h00, 1'b0, 1'b1, urun);
  endtask

  // ---------------- driver ----------------
  task automatic set_inputs(input int e);
    hs_request_i = (e >= req_from) && (e < req_to);
    tx_ready_i   = (e >= rdy_from) && !((e >= txd_from) && (e < txd_to));
    s_valid_i    = (src_idx < src_q.size()) && (src_idx < drop_at) && (e >= valid_from);
    s_data_i     = (src_idx < src_q.size()) ? src_q[src_idx] : 8'h00;
    s_last_i     = s_valid_i && (src_idx == src_q.size() - 1);
  endtask

  task automatic start(input int rq_from, input int rq_to, input int rd_from,
                       input int td_from, input int td_to, input int v_from,
                       input int drop);
    req_from   = rq_from;
    req_to     = rq_to;
    rdy_from   = rd_from;
    txd_from   = td_from;
    txd_to     = td_to;
    valid_from = v_from;
    drop_at    = drop;
    src_idx    = 0;
    k          = 0;
    set_inputs(0);
  endtask

  // Expand the segment table and compare one expected vector per cycle.
  task automatic run_expected();
    logic        fire;
    logic [16:0] e;
    string       nm;
    foreach (segs[i]) begin
      for (int j = 0; j < segs[i].n; j++) begin
        exp_q.push_back(segs[i].exp);
        name_q.push_back(segs[i].name);
      end
    end
    segs.delete();
    while (exp_q.size() > 0) begin
      fire = s_valid_i && s_ready_o;
      @(posedge byte_clock_i);
      #1;
      k++;
      if (fire) src_idx++;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, k - 1, act_vec(), e);
      set_inputs(k);
    end
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    hs_request_i = 1'b0;
    tx_ready_i   = 1'b0;
    s_valid_i    = 1'b0;
    s_last_i     = 1'b0;
    s_data_i     = 8'h00;
    repeat (2) @(posedge byte_clock_i);
    #1;
    check("reset", 0, act_vec(), vec(L_IDLE, 8'h00, 1'b0, 1'b0, 1'b0));
    reset_i = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    do_reset();

    // Nominal burst: 11,22,33, valid held, trail FF
    src_q = '{8'h11, 8'h22, 8'h33};
    add_pre();
    add_seg("dat_zero", 5, L_DHS, 8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("sync",     1, L_DHS, 8'hB8, 1'b1, 1'b1, 1'b0);
    add_seg("pay_11",   1, L_DHS, 8'h11, 1'b1, 1'b1, 1'b0);
    add_seg("pay_22",   1, L_DHS, 8'h22, 1'b1, 1'b1, 1'b0);
    add_seg("pay_33",   1, L_DHS, 8'h33, 1'b0, 1'b1, 1'b0);
    add_seg("trail_ff", 3, L_DHS, 8'hFF, 1'b0, 1'b1, 1'b0);
    add_post(1'b0);
    add_seg("idle",     2, L_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
    start(0, 1, 0, 0, 0, 0, 99);
    run_expected();
    do_reset();

    // Final byte with bit 7 set -> trail 00
    src_q = '{8'h5A, 8'h80};
    add_pre();
    add_seg("dat_zero", 5, L_DHS, 8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("sync",     1, L_DHS, 8'hB8, 1'b1, 1'b1, 1'b0);
    add_seg("pay_5a",   1, L_DHS, 8'h5A, 1'b1, 1'b1, 1'b0);
    add_seg("pay_80",   1, L_DHS, 8'h80, 1'b0, 1'b1, 1'b0);
    add_seg("trail_00", 3, L_DHS, 8'h00, 1'b0, 1'b1, 1'b0);
    add_post(1'b0);
    add_seg("idle",     1, L_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
    start(0, 1, 0, 0, 0, 0, 99);
    run_expected();
    do_reset();

    // Valid late by 3 cycles after HS-zero expiry -> DAT_ZERO 8 cycles
    src_q = '{8'h3C};
    add_pre();
    add_seg("dat_zero8", 8, L_DHS, 8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("sync",      1, L_DHS, 8'hB8, 1'b1, 1'b1, 1'b0);
    add_seg("pay_3c",    1, L_DHS, 8'h3C, 1'b0, 1'b1, 1'b0);
    add_seg("trail_ff",  3, L_DHS, 8'hFF, 1'b0, 1'b1, 1'b0);
    add_post(1'b0);
    add_seg("idle",      1, L_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
    start(0, 1, 0, 0, 0, 28, 99);
    run_expected();
    do_reset();

    // Underrun after 2nd of 4 bytes: trail keyed on B2, sticky flag
    src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    add_pre();
    add_seg("dat_zero", 5, L_DHS, 8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("sync",     1, L_DHS, 8'hB8, 1'b1, 1'b1, 1'b0);
    add_seg("pay_a1",   1, L_DHS, 8'hA1, 1'b1, 1'b1, 1'b0);
    add_seg("pay_b2",   1, L_DHS, 8'hB2, 1'b1, 1'b1, 1'b0);
    add_seg("ur_trail", 3, L_DHS, 8'h00, 1'b0, 1'b1, 1'b1);
    add_post(1'b1);
    add_seg("ur_idle",  3, L_IDLE, 8'h00, 1'b0, 1'b0, 1'b1);
    start(0, 1, 0, 0, 0, 0, 2);
    run_expected();
    do_reset();

    // Reset pulsed during PAYLOAD -> LP-11, HS off, no trail
    src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    add_pre();
    add_seg("dat_zero", 5, L_DHS, 8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("sync",     1, L_DHS, 8'hB8, 1'b1, 1'b1, 1'b0);
    add_seg("pay_a1",   1, L_DHS, 8'hA1, 1'b1, 1'b1, 1'b0);
    add_seg("pay_b2",   1, L_DHS, 8'hB2, 1'b1, 1'b1, 1'b0);
    start(0, 1, 0, 0, 0, 0, 99);
    run_expected();
    reset_i = 1'b1;
    @(posedge byte_clock_i);
    #1;
    check("reset_mid_payload", 0, act_vec(), vec(L_IDLE, 8'h00, 1'b0, 1'b0, 1'b0));
    reset_i   = 1'b0;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    repeat (2) begin
      @(posedge byte_clock_i);
      #1;
      check("idle_after_reset", 0, act_vec(), vec(L_IDLE, 8'h00, 1'b0, 1'b0, 1'b0));
    end
    do_reset();

    // Request waits for tx_ready; tx_ready drop mid-burst ignored;
    // request held high restarts after one IDLE cycle
    src_q = '{8'h7F};
    add_seg("wait_ready", 10, L_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
    add_pre();
    add_seg("dat_zero", 5, L_DHS, 8'h00, 1'b0, 1'b1, 1'b0);
    add_seg("sync",     1, L_DHS, 8'hB8, 1'b1, 1'b1, 1'b0);
    add_seg("pay_7f",   1, L_DHS, 8'h7F, 1'b0, 1'b1, 1'b0);
    add_seg("trail_ff", 3, L_DHS, 8'hFF, 1'b0, 1'b1, 1'b0);
    add_post(1'b0);
    add_seg("idle_gap", 1, L_IDLE, 8'h00, 1'b0, 1'b0, 1'b0);
    add_seg("restart",  2, L_CLPX, 8'h00, 1'b0, 1'b1, 1'b0);
    start(0, 100000, 10, 20, 30, 0, 99);
    run_expected();
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
